mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares one single-ported `ext_mem` instance between the rv32 core's instruction and data memory interfaces. It sits between the core's `ext_mem_imem_*` / `ext_mem_dmem_*` ports and a single `ext_mem`. It arbitrates requests, keeps one request outstanding at the memory, and routes each response back to its issuer through a per-client response buffer. A watchdog synthesizes an error response if the memory never answers.

## Interface
Bus format, all 70-bit ports:
- arg[69] = get_ready; arg[68] = put_valid; arg[67:0] = put_request {byte_en[3:0], addr[31:0], data[31:0]}.
- out[69] = get_valid; out[68] = put_ready; out[67:0] = get_response, same layout.

Parameters:
- MAX_WAIT, 255: cycles to wait for a memory response before timeout; range 1..65535.

Ports:
- CLK  input  1  clock, all state on posedge.
- RST_N  input  1  reset. Asynchronous and active-high: asserted when 1.
- imem_arg  input  70  instruction-client request and get_ready.
- imem_out  output  70  instruction-client response and put_ready.
- dmem_arg  input  70  data-client request and get_ready.
- dmem_out  output  70  data-client response and put_ready.
- mem_arg  output  70  request to the shared ext_mem.
- mem_out  input  70  response from the shared ext_mem.
- timeout_err  output  1  sticky flag, set on any watchdog expiry.

## Operation
- **FSM states:** IDLE, ISSUE, WAIT.
- **Client put_ready:** asserted for a client only when all of the following hold:
  - state is IDLE;
  - that client holds the grant;
  - that client's response buffer is empty.
  - Combinational on current state and buffers; never depends on put_valid.
- **Grant (round-robin):** among eligible requesters (put_valid=1, buffer empty), the one not granted last wins. With a single eligible requester, it wins.
  - `last` resets to imem, so dmem wins the first tie.
  - `last` updates only on acceptance.
- **IDLE:** on accept (put_valid & put_ready), latch put_request and the owner ID, then go to ISSUE.
- **ISSUE:**
  - Drive mem_arg put_valid=1 with the latched request.
  - When mem_out put_ready=1, go to WAIT and clear the watchdog counter.
- **WAIT:**
  - Drive mem_arg get_ready=1.
  - When mem_out get_valid=1, copy get_response into the owner's buffer, then go to IDLE.
  - The counter increments each WAIT cycle. When it reaches MAX_WAIT, fill the owner's buffer with {4'h0, latched addr, 32'hDEAD_BEEF}, set timeout_err, and go to IDLE.
  - A late memory response arriving after a timeout (get_ready=0 in IDLE/ISSUE) is not consumed and is ignored.
- **Responses:** every accepted request, read or write, yields exactly one response.
- **Response buffers:**
  - One entry per client.
  - Client get_valid = buffer full; get_response = buffer contents.
  - The buffer empties on the cycle where get_valid & get_ready.
- **Simultaneous fill and drain:** fill and drain of the same buffer in one cycle cannot occur, because a fill requires the owner's buffer to have been empty at accept.
- **Outputs outside the active state:** mem_arg put_valid=0 outside ISSUE; get_ready=0 outside WAIT. Request fields hold the latched value.
- **Reset:** asserting RST_N at any time, including mid-transaction, forces:
  - state to IDLE, both buffers empty, `last` to imem, counter to 0, timeout_err to 0;
  - all output fields to 0.
  - No in-flight response is delivered after reset.

## Timing
- **Accept:** cycle t in IDLE. Memory put_valid is visible in cycle t+1.
- **Minimum latency, accept to client get_valid:**
  - memory put_ready in t+1, then get_valid in t+2;
  - buffer full and client get_valid high in t+3.
- **Next accept:** earliest next accept is t+3 (IDLE).
- **Throughput:** at most one request per 3 cycles.
- **Timeout timing:** with no memory response, the error response is visible at t+2+MAX_WAIT.
- **Backpressure:** a client that never raises get_ready blocks only itself. The other client continues to be served.

## Configuration
- **Macro:** MEM_ARB_DMEM_PRIO_EN.
- **Defined:** fixed priority. dmem always wins when eligible; imem is granted only when dmem is not eligible. `last` is unused.
- **Undefined (default):** round-robin as described above.

## Test plan
- **Single read:** imem put_valid, addr 0x100, byte_en 0; memory returns data 0x00000013 one cycle after put_ready -> imem get_valid at t+3 with data 0x00000013; dmem_out get_valid stays 0.
- **Simultaneous requests:** both clients put_valid from reset -> dmem accepted first, imem next; each response returned to its owner. Without MEM_ARB_DMEM_PRIO_EN, 6 back-to-back requests alternate dmem, imem, dmem, and so on. With the macro, dmem gets all of them while it keeps requesting.
- **Backpressure:** dmem get_ready=0 with its buffer full -> dmem put_ready=0; imem requests continue to complete; dmem response is held unchanged until get_ready=1.
- **Timeout:** MAX_WAIT=4 and memory never asserts get_valid -> owner receives data 0xDEADBEEF with the latched addr at t+6; timeout_err=1 and stays 1.
- **Reset mid-transaction:** RST_N pulse while in WAIT -> all outputs 0 and both buffers empty. The memory response arriving after reset is not delivered, and the next request completes normally.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported ext_mem between the imem and dmem clients: one request outstanding,
// per-client one-entry response buffers, watchdog error response. MEM_ARB_DMEM_PRIO_EN selects fixed dmem priority.
`timescale 1ns/1ps
module mem_port_arbiter #(
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [69:0] imem_arg,
  output logic [69:0] imem_out,
  input  logic [69:0] dmem_arg,
  output logic [69:0] dmem_out,
  output logic [69:0] mem_arg,
  input  logic [69:0] mem_out,
  output logic        timeout_err
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  localparam logic        OWN_I     = 1'b0;
  localparam logic        OWN_D     = 1'b1;
  localparam logic [15:0] WAIT_LAST = 16'(MAX_WAIT - 1);

  state_t      state;
  logic        owner;
  logic [67:0] req_q;
  logic [15:0] wait_cnt;
  logic        ibuf_vld, dbuf_vld;
  logic [67:0] ibuf, dbuf;
`ifndef MEM_ARB_DMEM_PRIO_EN
  logic        last;
`endif

  logic        i_pv, i_gr, d_pv, d_gr, mem_gv, mem_pr;
  logic        i_elig, d_elig, i_grant, d_grant;
  logic        i_rdy, d_rdy, i_acc, d_acc;
  logic        fill_en;
  logic [67:0] fill_data;

  function automatic logic [67:0] timeout_resp(input logic [31:0] addr);
    return {4'h0, addr, 32'hDEAD_BEEF};
  endfunction

  always_comb begin
    i_pv   = imem_arg[68];
    i_gr   = imem_arg[69];
    d_pv   = dmem_arg[68];
    d_gr   = dmem_arg[69];
    mem_gv = mem_out[69];
    mem_pr = mem_out[68];
    i_elig = i_pv & ~ibuf_vld;
    d_elig = d_pv & ~dbuf_vld;
`ifdef MEM_ARB_DMEM_PRIO_EN
    d_grant = ~dbuf_vld;
    i_grant = ~ibuf_vld & ~d_elig;
`else
    // A client holds the grant unless the other is eligible and is due its turn.
    i_grant = ~ibuf_vld & (~d_elig | (last == OWN_D));
    d_grant = ~dbuf_vld & (~i_elig | (last == OWN_I));
`endif
    i_rdy  = (state == IDLE) & i_grant & ~RST_N;
    d_rdy  = (state == IDLE) & d_grant & ~RST_N;
    i_acc  = i_pv & i_rdy;
    d_acc  = d_pv & d_rdy;

    fill_en   = (state == WAIT) & (mem_gv | (wait_cnt == WAIT_LAST));
    fill_data = mem_gv ? mem_out[67:0] : timeout_resp(req_q[63:32]);

    imem_out = {ibuf_vld, i_rdy, ibuf};
    dmem_out = {dbuf_vld, d_rdy, dbuf};
    mem_arg  = {(state == WAIT), (state == ISSUE), req_q};
  end

  always_ff @(posedge CLK or posedge RST_N) begin
    if (RST_N) begin
      state       <= IDLE;
      owner       <= OWN_I;
      req_q       <= '0;
      wait_cnt    <= '0;
      ibuf_vld    <= 1'b0;
      dbuf_vld    <= 1'b0;
      ibuf        <= '0;
      dbuf        <= '0;
      timeout_err <= 1'b0;
`ifndef MEM_ARB_DMEM_PRIO_EN
      last        <= OWN_I;
`endif
    end else begin
      if (ibuf_vld & i_gr) ibuf_vld <= 1'b0;
      if (dbuf_vld & d_gr) dbuf_vld <= 1'b0;

      case (state)
        IDLE: begin
          if (d_acc) begin
            req_q <= dmem_arg[67:0];
            owner <= OWN_D;
            state <= ISSUE;
`ifndef MEM_ARB_DMEM_PRIO_EN
            last  <= OWN_D;
`endif
          end else if (i_acc) begin
            req_q <= imem_arg[67:0];
            owner <= OWN_I;
            state <= ISSUE;
`ifndef MEM_ARB_DMEM_PRIO_EN
            last  <= OWN_I;
`endif
          end
        end
        ISSUE: begin
          if (mem_pr) begin
            wait_cnt <= '0;
            state    <= WAIT;
          end
        end
        WAIT: begin
          // A real response wins over a watchdog expiry in the same cycle.
          if (fill_en) begin
            if (owner == OWN_D) begin
              dbuf     <= fill_data;
              dbuf_vld <= 1'b1;
            end else begin
              ibuf     <= fill_data;
              ibuf_vld <= 1'b1;
            end
            if (!mem_gv) timeout_err <= 1'b1;
            state <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: client drivers push expected responses,
// negedge monitors pop and compare; a small ext_mem model checks issue order.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

  localparam int MW = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_gr, i_pv, d_gr, d_pv;
  logic [67:0] i_req, d_req;
  logic        m_gv, m_pr;
  logic [67:0] m_resp;
  logic [69:0] imem_arg, imem_out, dmem_arg, dmem_out, mem_arg, mem_out;
  logic        timeout_err;

  assign imem_arg = {i_gr, i_pv, i_req};
  assign dmem_arg = {d_gr, d_pv, d_req};
  assign mem_out  = {m_gv, m_pr, m_resp};

  int n_checks = 0;
  int n_fail   = 0;

  logic [67:0] exp_i[$];
  logic [67:0] exp_d[$];
  logic [31:0] exp_iss[$];

  bit          pr_en   = 1'b1;
  bit          resp_en = 1'b1;
  bit          pend    = 1'b0;
  bit          gr_prev = 1'b0;
  logic [67:0] preq    = '0;

  mem_port_arbiter #(.MAX_WAIT(MW)) dut (
    .CLK(clk),
    .RST_N(rst),
    .imem_arg(imem_arg),
    .imem_out(imem_out),
    .dmem_arg(dmem_arg),
    .dmem_out(dmem_out),
    .mem_arg(mem_arg),
    .mem_out(mem_out),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [69:0] act, input logic [69:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // ext_mem contents for the addresses the vectors use.
  function automatic logic [31:0] rom(input logic [31:0] a);
    case (a)
      32'h100: return 32'h0000_0013;
      32'h104: return 32'h0010_0093;
      32'h108: return 32'h0020_8113;
      32'h10C: return 32'h0031_0193;
      32'h200: return 32'hCAFE_0001;
      32'h208: return 32'hCAFE_0003;
      32'h20C: return 32'hCAFE_0004;
      default: return 32'h0BAD_0000;
    endcase
  endfunction

  // ext_mem model: always ready, answers one cycle after accepting a request.
  initial begin
    m_gv = 1'b0; m_pr = 1'b0; m_resp = '0;
    forever begin
      @(negedge clk);
      if (m_gv && gr_prev) m_gv = 1'b0;
      if (pend && resp_en && !m_gv) begin
        m_gv   = 1'b1;
        m_resp = (preq[67:64] != 4'h0) ? preq : {preq[67:32], rom(preq[63:32])};
        pend   = 1'b0;
      end
      m_pr = pr_en;
      if (mem_arg[68] && m_pr) begin
        pend = 1'b1;
        preq = mem_arg[67:0];
        if (exp_iss.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL issue_unexpected: got addr %h, expected no request", mem_arg[63:32]);
        end else begin
          logic [31:0] ea;
          ea = exp_iss.pop_front();
          chk("issue_order", 70'(mem_arg[63:32]), 70'(ea));
        end
      end
      gr_prev = mem_arg[69];
    end
  end

  always @(negedge clk) begin
    if (!rst && imem_out[69] && i_gr) begin
      if (exp_i.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL imem_unexpected_resp: got %h, expected none", imem_out[67:0]);
      end else begin
        logic [67:0] e;
        e = exp_i.pop_front();
        chk("imem_resp", 70'(imem_out[67:0]), 70'(e));
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && dmem_out[69] && d_gr) begin
      if (exp_d.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL dmem_unexpected_resp: got %h, expected none", dmem_out[67:0]);
      end else begin
        logic [67:0] e;
        e = exp_d.pop_front();
        chk("dmem_resp", 70'(dmem_out[67:0]), 70'(e));
      end
    end
  end

  // Present one request and return one time unit after the accepting edge.
  task automatic send(input bit is_d, input logic [67:0] req, input logic [67:0] rsp, input bit want);
    int n;
    bit acc;
    n = 0;
    acc = 1'b0;
    if (want) begin
      if (is_d) exp_d.push_back(rsp);
      else      exp_i.push_back(rsp);
    end
    if (is_d) begin d_req = req; d_pv = 1'b1; end
    else      begin i_req = req; i_pv = 1'b1; end
    while (!acc && n < 100) begin
      @(negedge clk);
      acc = is_d ? dmem_out[68] : imem_out[68];
      n++;
    end
    if (!acc) begin
      n_checks++; n_fail++;
      $display("FAIL %s_accept_timeout: got no put_ready, expected put_ready within 100 cycles",
               is_d ? "dmem" : "imem");
      if (want) begin
        if (is_d) void'(exp_d.pop_back());
        else      void'(exp_i.pop_back());
      end
    end
    @(posedge clk); #1;
    if (is_d) d_pv = 1'b0;
    else      i_pv = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no end of test, expected end within 200000 time units");
    $fatal(1, "bench timeout");
  end

  initial begin
    i_gr = 1'b1; i_pv = 1'b0; i_req = '0;
    d_gr = 1'b1; d_pv = 1'b0; d_req = '0;
    rst  = 1'b1;

    repeat (2) @(negedge clk);
    chk("reset_imem_out", imem_out, 70'h0);
    chk("reset_dmem_out", dmem_out, 70'h0);
    chk("reset_mem_arg", mem_arg, 70'h0);
    chk("reset_timeout_err", 70'(timeout_err), 70'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(1);

    // Single read with cycle-exact latency.
    exp_iss.push_back(32'h100);
    send(1'b0, {4'h0, 32'h100, 32'h0}, {4'h0, 32'h100, 32'h0000_0013}, 1'b1);
    @(negedge clk);
    chk("single_mem_put_valid_t1", 70'(mem_arg[68]), 70'h1);
    @(negedge clk);
    chk("single_imem_gv_t2", 70'(imem_out[69]), 70'h0);
    chk("single_mem_get_ready_t2", 70'(mem_arg[69]), 70'h1);
    @(negedge clk);
    chk("single_imem_gv_t3", 70'(imem_out[69]), 70'h1);
    chk("single_dmem_gv_t3", 70'(dmem_out[69]), 70'h0);
    idle(3);

    // Both clients streaming: dmem wins the first tie, then strict alternation.
    exp_iss.push_back(32'h200); exp_iss.push_back(32'h104);
    exp_iss.push_back(32'h204); exp_iss.push_back(32'h108);
    exp_iss.push_back(32'h208); exp_iss.push_back(32'h10C);
    fork
      begin
        send(1'b1, {4'h0, 32'h200, 32'h0},          {4'h0, 32'h200, 32'hCAFE_0001}, 1'b1);
        send(1'b1, {4'hF, 32'h204, 32'h1234_5678}, {4'hF, 32'h204, 32'h1234_5678}, 1'b1);
        send(1'b1, {4'h0, 32'h208, 32'h0},          {4'h0, 32'h208, 32'hCAFE_0003}, 1'b1);
      end
      begin
        send(1'b0, {4'h0, 32'h104, 32'h0}, {4'h0, 32'h104, 32'h0010_0093}, 1'b1);
        send(1'b0, {4'h0, 32'h108, 32'h0}, {4'h0, 32'h108, 32'h0020_8113}, 1'b1);
        send(1'b0, {4'h0, 32'h10C, 32'h0}, {4'h0, 32'h10C, 32'h0031_0193}, 1'b1);
      end
    join
    idle(5);

    // dmem stalls its response; imem keeps being served.
    d_gr = 1'b0;
    exp_iss.push_back(32'h20C);
    send(1'b1, {4'h0, 32'h20C, 32'h0}, {4'h0, 32'h20C, 32'hCAFE_0004}, 1'b1);
    idle(3);
    @(negedge clk);
    chk("bp_dmem_put_ready", 70'(dmem_out[68]), 70'h0);
    @(posedge clk); #1;
    exp_iss.push_back(32'h100); exp_iss.push_back(32'h104);
    send(1'b0, {4'h0, 32'h100, 32'h0}, {4'h0, 32'h100, 32'h0000_0013}, 1'b1);
    send(1'b0, {4'h0, 32'h104, 32'h0}, {4'h0, 32'h104, 32'h0010_0093}, 1'b1);
    idle(3);
    @(negedge clk);
    chk("bp_dmem_held", dmem_out, {1'b1, 1'b0, 4'h0, 32'h20C, 32'hCAFE_0004});
    @(posedge clk); #1;
    d_gr = 1'b1;
    idle(2);
    @(negedge clk);
    chk("bp_dmem_drained", 70'(dmem_out[69]), 70'h0);
    @(posedge clk); #1;

    // Memory never answers: watchdog response at accept + 2 + MAX_WAIT.
    resp_en = 1'b0;
    exp_iss.push_back(32'h300);
    send(1'b0, {4'h3, 32'h300, 32'h0000_0055}, {4'h0, 32'h300, 32'hDEAD_BEEF}, 1'b1);
    repeat (5) @(negedge clk);
    chk("to_imem_gv_t5", 70'(imem_out[69]), 70'h0);
    @(negedge clk);
    chk("to_imem_gv_t6", 70'(imem_out[69]), 70'h1);
    chk("to_err_set", 70'(timeout_err), 70'h1);
    @(posedge clk); #1;
    pend = 1'b0;
    resp_en = 1'b1;
    idle(4);
    @(negedge clk);
    chk("to_err_sticky", 70'(timeout_err), 70'h1);
    @(posedge clk); #1;

    // Reset while waiting on memory; the late response must not surface.
    resp_en = 1'b0;
    exp_iss.push_back(32'h104);
    send(1'b0, {4'h0, 32'h104, 32'h0}, '0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("rst_in_wait", 70'(mem_arg[69]), 70'h1);
    rst = 1'b1;
    #1;
    chk("rst_imem_out", imem_out, 70'h0);
    chk("rst_dmem_out", dmem_out, 70'h0);
    chk("rst_mem_arg", mem_arg, 70'h0);
    chk("rst_timeout_err", 70'(timeout_err), 70'h0);
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    resp_en = 1'b1;
    idle(4);
    @(negedge clk);
    chk("rst_no_stale_imem", 70'(imem_out[69]), 70'h0);
    chk("rst_no_stale_dmem", 70'(dmem_out[69]), 70'h0);
    @(posedge clk); #1;
    m_gv = 1'b0;
    pend = 1'b0;
    exp_iss.push_back(32'h108);
    send(1'b0, {4'h0, 32'h108, 32'h0}, {4'h0, 32'h108, 32'h0020_8113}, 1'b1);
    idle(5);

    chk("imem_all_delivered", 70'(exp_i.size()), 70'h0);
    chk("dmem_all_delivered", 70'(exp_d.size()), 70'h0);
    chk("all_issued", 70'(exp_iss.size()), 70'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
